// File: rtl/seg_scan_mux.sv
// ============================================================================
//  Module      : seg_scan_mux
//  Description : Multiplexed 7-segment hex scanner that shows one of NCH
//                watch channels, selected manually or by timed auto-rotation.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module seg_scan_mux #(
   parameter  int WIDTH      = 16,
   parameter  int NCH        = 2,
   parameter  int SCAN_DIV   = 1024,
   parameter  int ROT_FRAMES = 256,
   localparam int DIGITS     = WIDTH / 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NCH*WIDTH-1:0] vals,
   input  logic [2:0]           sel,
   input  logic                 auto_rot,
   input  logic                 hold,
   input  logic                 blank_lz,
   output logic [7:0]           seg,
   output logic [DIGITS-1:0]    seg_sel,
   output logic [2:0]           ch_idx
);

   localparam int c_presc_w = $clog2(SCAN_DIV);
   localparam int c_digit_w = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int c_frame_w = $clog2(ROT_FRAMES + 1);

   localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(SCAN_DIV - 1);
   localparam logic [c_digit_w-1:0] c_digit_last = c_digit_w'(DIGITS - 1);
   localparam logic [c_frame_w-1:0] c_frame_last = c_frame_w'(ROT_FRAMES - 1);
   localparam logic [2:0]           c_ch_last    = 3'(NCH - 1);
   localparam logic [3:0]           c_nch        = 4'(NCH);

   logic [c_presc_w-1:0] r_presc;
   logic [c_digit_w-1:0] r_digit;
   logic [c_frame_w-1:0] r_frame;
   logic [2:0]           r_chan;
   logic [WIDTH-1:0]     r_snap;
   logic [2:0]           r_ch_idx;
   logic [7:0]           r_seg;
   logic [DIGITS-1:0]    r_seg_sel;

   logic                 w_tick;
   logic                 w_frame_end;
   logic                 w_load;
   logic [c_digit_w-1:0] w_digit_nxt;
   logic [2:0]           w_sel_clamp;
   logic [2:0]           w_active;
   logic [WIDTH-1:0]     w_chan_val;
   logic [WIDTH-1:0]     w_snap_nxt;
   logic [2:0]           w_ch_idx_nxt;
   logic [DIGITS-1:0]    w_zero_above;
   logic [3:0]           w_nib;
   logic                 w_zero_sel;
   logic                 w_blank;
   logic [DIGITS-1:0]    w_seg_sel_nxt;
   logic [7:0]           w_seg_nxt;

   // Active-low a..g pattern for one hex nibble.
   function automatic logic [6:0] hex7(input logic [3:0] nib);
      logic [6:0] p;
      case (nib)
         4'h0:    p = 7'h40;
         4'h1:    p = 7'h79;
         4'h2:    p = 7'h24;
         4'h3:    p = 7'h30;
         4'h4:    p = 7'h19;
         4'h5:    p = 7'h12;
         4'h6:    p = 7'h02;
         4'h7:    p = 7'h78;
         4'h8:    p = 7'h00;
         4'h9:    p = 7'h10;
         4'hA:    p = 7'h08;
         4'hB:    p = 7'h03;
         4'hC:    p = 7'h46;
         4'hD:    p = 7'h21;
         4'hE:    p = 7'h06;
         default: p = 7'h0E;
      endcase
      return p;
   endfunction

   assign w_tick      = (r_presc == c_presc_last);
   assign w_frame_end = w_tick && (r_digit == c_digit_last);
   assign w_load      = w_frame_end && !hold;
   assign w_digit_nxt = (r_digit == c_digit_last) ? '0 : r_digit + c_digit_w'(1);

   assign w_sel_clamp = ({1'b0, sel} >= c_nch) ? c_ch_last : sel;
   assign w_active    = auto_rot ? r_chan : w_sel_clamp;

   always_comb begin
      w_chan_val = '0;
      for (int k = 0; k < NCH; k++) begin
         if (w_active == 3'(k)) begin
            w_chan_val = vals[k*WIDTH +: WIDTH];
         end
      end
   end

   assign w_snap_nxt   = w_load ? w_chan_val : r_snap;
   assign w_ch_idx_nxt = w_load ? w_active   : r_ch_idx;

   // Decode looks at the snapshot as it will be after this edge, so a new
   // frame's digit 0 already shows the freshly loaded value.
   always_comb begin
      w_zero_above             = '0;
      w_nib                    = 4'h0;
      w_zero_sel               = 1'b0;
      w_seg_sel_nxt            = '1;
      w_zero_above[DIGITS-1]   = (w_snap_nxt[4*(DIGITS-1) +: 4] == 4'h0);
      for (int k = DIGITS - 2; k >= 0; k--) begin
         w_zero_above[k] = w_zero_above[k+1] && (w_snap_nxt[4*k +: 4] == 4'h0);
      end
      for (int k = 0; k < DIGITS; k++) begin
         if (w_digit_nxt == c_digit_w'(k)) begin
            w_nib            = w_snap_nxt[4*k +: 4];
            w_zero_sel       = w_zero_above[k];
            w_seg_sel_nxt[k] = 1'b0;
         end
      end
   end

   assign w_blank   = blank_lz && (w_digit_nxt != '0) && w_zero_sel;
   assign w_seg_nxt = {~(hold && (w_digit_nxt == '0)), w_blank ? 7'h7F : hex7(w_nib)};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_presc   <= '0;
         r_digit   <= c_digit_last;
         r_frame   <= '0;
         r_chan    <= '0;
         r_snap    <= '0;
         r_ch_idx  <= '0;
         r_seg     <= 8'hFF;
         r_seg_sel <= '1;
      end else begin
         r_presc <= w_tick ? '0 : r_presc + c_presc_w'(1);

         // Manual mode keeps the rotation pointer on the selected channel so
         // enabling auto mode starts from it with a fresh frame count.
         if (!auto_rot) begin
            r_chan  <= w_sel_clamp;
            r_frame <= '0;
         end else if (w_load) begin
            if (r_frame == c_frame_last) begin
               r_frame <= '0;
               r_chan  <= (r_chan == c_ch_last) ? 3'd0 : r_chan + 3'd1;
            end else begin
               r_frame <= r_frame + c_frame_w'(1);
            end
         end

         if (w_tick) begin
            r_digit   <= w_digit_nxt;
            r_snap    <= w_snap_nxt;
            r_ch_idx  <= w_ch_idx_nxt;
            r_seg     <= w_seg_nxt;
            r_seg_sel <= w_seg_sel_nxt;
         end
      end
   end

   assign seg     = r_seg;
   assign seg_sel = r_seg_sel;
   assign ch_idx  = r_ch_idx;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_mux.sv
// ============================================================================
//  Module      : tb_seg_scan_mux
//  Description : Table-driven scoreboard bench for seg_scan_mux.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seg_scan_mux;

   localparam int WIDTH      = 16;
   localparam int NCH        = 3;
   localparam int SCAN_DIV   = 4;
   localparam int ROT_FRAMES = 2;

   logic                 clock = 1'b0;
   logic                 reset = 1'b1;
   logic [NCH*WIDTH-1:0] vals;
   logic [2:0]           sel;
   logic                 auto_rot;
   logic                 hold;
   logic                 blank_lz;
   logic [7:0]           seg;
   logic [3:0]           seg_sel;
   logic [2:0]           ch_idx;

   always #5 clock = ~clock;

   seg_scan_mux #(
      .WIDTH      (WIDTH),
      .NCH        (NCH),
      .SCAN_DIV   (SCAN_DIV),
      .ROT_FRAMES (ROT_FRAMES)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .vals     (vals),
      .sel      (sel),
      .auto_rot (auto_rot),
      .hold     (hold),
      .blank_lz (blank_lz),
      .seg      (seg),
      .seg_sel  (seg_sel),
      .ch_idx   (ch_idx)
   );

   typedef struct packed {
      logic [7:0] seg;
      logic [3:0] sel;
      logic [2:0] ch;
   } exp_t;

   // segs holds the four digit patterns, digit 0 in the low byte.
   typedef struct packed {
      logic [47:0] vals;
      logic [2:0]  sel;
      logic        blz;
      logic        hold;
      logic [31:0] segs;
      logic [2:0]  ch;
   } vec_t;

   exp_t sb[$];
   exp_t last_exp;
   vec_t tbl[14];
   int   n_tests = 0;
   int   n_fail  = 0;

   localparam exp_t c_rst_exp = '{8'hFF, 4'hF, 3'd0};

   task automatic push_frame(input logic [31:0] segs, input logic [2:0] ch);
      exp_t e;
      for (int d = 0; d < 4; d++) begin
         e.seg = segs[d*8 +: 8];
         e.sel = ~(4'(1) << d);
         e.ch  = ch;
         sb.push_back(e);
      end
   endtask

   task automatic cmp(input string name, input exp_t req);
      n_tests++;
      if ({seg, seg_sel, ch_idx} !== req) begin
         n_fail++;
         $display("FAIL %s: got seg=%h seg_sel=%b ch_idx=%0d, want seg=%h seg_sel=%b ch_idx=%0d",
                  name, seg, seg_sel, ch_idx, req.seg, req.sel, req.ch);
      end
   endtask

   // Called just after a tick: checks outputs hold until the cycle before the
   // next tick, then pops and compares the value the next tick must produce.
   task automatic tick_check(input string name);
      exp_t e;
      repeat (SCAN_DIV - 1) @(posedge clock);
      #1;
      cmp({name, "_stable"}, last_exp);
      @(posedge clock);
      #1;
      if (sb.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: scoreboard empty at tick", name);
      end else begin
         e = sb.pop_front();
         cmp(name, e);
         last_exp = e;
      end
   endtask

   task automatic run_ticks(input int n, input string name);
      for (int i = 0; i < n; i++) tick_check(name);
   endtask

   function automatic logic [31:0] ch_segs(input logic [2:0] ch);
      case (ch)
         3'd0:    return 32'hC0C0C0C0;
         3'd1:    return 32'hF9F9F9F9;
         default: return 32'hA4A4A4A4;
      endcase
   endfunction

   initial begin
      logic [2:0] rot_seq [7];
      rot_seq = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd0};

      //                vals                         sel   blz   hold  segs          ch
      tbl[0]  = '{48'h0000_0000_12AF, 3'd0, 1'b0, 1'b0, 32'hF9A4888E, 3'd0};
      tbl[1]  = '{48'h0000_0000_0005, 3'd0, 1'b1, 1'b0, 32'hFFFFFF92, 3'd0};
      tbl[2]  = '{48'h0000_0000_0000, 3'd0, 1'b1, 1'b0, 32'hFFFFFFC0, 3'd0};
      tbl[3]  = '{48'h0000_0000_0000, 3'd0, 1'b0, 1'b0, 32'hC0C0C0C0, 3'd0};
      tbl[4]  = '{48'h0000_0000_0305, 3'd0, 1'b1, 1'b0, 32'hFFB0C092, 3'd0};
      tbl[5]  = '{48'h0000_0000_7B6C, 3'd0, 1'b1, 1'b0, 32'hF88382C6, 3'd0};
      tbl[6]  = '{48'h0000_0000_4D9E, 3'd0, 1'b0, 1'b0, 32'h99A19086, 3'd0};
      tbl[7]  = '{48'h0000_0000_00F8, 3'd0, 1'b1, 1'b0, 32'hFFFF8E80, 3'd0};
      tbl[8]  = '{48'h0000_0000_1000, 3'd0, 1'b1, 1'b0, 32'hF9C0C0C0, 3'd0};
      tbl[9]  = '{48'h0000_0000_ABCD, 3'd0, 1'b1, 1'b1, 32'hF9C0C040, 3'd0};
      tbl[10] = '{48'h0000_0000_ABCD, 3'd0, 1'b1, 1'b0, 32'h8883C6A1, 3'd0};
      tbl[11] = '{48'h5A5A_0000_ABCD, 3'd6, 1'b0, 1'b0, 32'h92889288, 3'd2};
      tbl[12] = '{48'h5A5A_0C00_ABCD, 3'd1, 1'b1, 1'b0, 32'hFFC6C0C0, 3'd1};
      tbl[13] = '{48'h00E0_0C00_ABCD, 3'd3, 1'b1, 1'b0, 32'hFFFF86C0, 3'd2};

      vals     = '0;
      sel      = 3'd0;
      auto_rot = 1'b0;
      hold     = 1'b0;
      blank_lz = 1'b0;
      reset    = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      cmp("reset_state", c_rst_exp);
      reset    = 1'b0;
      last_exp = c_rst_exp;

      // Manual-mode table: each entry is one full frame.
      for (int i = 0; i < 14; i++) begin
         vals     = tbl[i].vals;
         sel      = tbl[i].sel;
         blank_lz = tbl[i].blz;
         hold     = tbl[i].hold;
         push_frame(tbl[i].segs, tbl[i].ch);
         run_ticks(4, $sformatf("vec%0d", i));
      end

      // Mid-frame value change must not disturb the frame in progress.
      vals     = 48'h0000_0000_1111;
      sel      = 3'd0;
      blank_lz = 1'b0;
      hold     = 1'b0;
      push_frame(32'hF9F9F9F9, 3'd0);
      push_frame(32'hA4A4A4A4, 3'd0);
      tick_check("midframe_d0");
      vals = 48'h0000_0000_2222;
      run_ticks(3, "midframe_rest");
      run_ticks(4, "midframe_next");

      // Auto rotation from manual channel 0.
      vals     = 48'h2222_1111_0000;
      auto_rot = 1'b1;
      for (int f = 0; f < 7; f++) push_frame(ch_segs(rot_seq[f]), rot_seq[f]);
      run_ticks(28, "auto_rot");

      // Hold freezes snapshot and rotation; dp lit on digit 0.
      hold = 1'b1;
      vals = 48'h2222_1111_3333;
      push_frame(32'hC0C0C040, 3'd0);
      push_frame(32'hC0C0C040, 3'd0);
      run_ticks(8, "auto_hold");
      hold = 1'b0;
      push_frame(32'hB0B0B0B0, 3'd0);
      push_frame(32'hF9F9F9F9, 3'd1);
      run_ticks(8, "auto_resume");

      // Back to manual with an explicit channel.
      auto_rot = 1'b0;
      sel      = 3'd2;
      push_frame(32'hA4A4A4A4, 3'd2);
      run_ticks(4, "manual_return");

      // Asynchronous reset in the middle of a digit slot.
      @(posedge clock);
      #2;
      reset = 1'b1;
      #1;
      cmp("async_reset", c_rst_exp);
      @(posedge clock);
      #1;
      reset    = 1'b0;
      sel      = 3'd1;
      last_exp = c_rst_exp;
      push_frame(32'hF9F9F9F9, 3'd1);
      run_ticks(4, "post_reset");

      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: got %0d entries left, want 0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
